nn_load_sequencer: RTL and testbench
====================================

NN_LOAD_SEQUENCER -- requirements
Module: nn_load_sequencer

Interface
REQ-001 Parameter N_PARAM, default 20: parameter bytes per full load (4 neurons x 4 weights + 4 biases).
REQ-002 Parameter COMPUTE_CYCLES, default 2: cycles compute_en is held high before results are read; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 data_in  input  8  byte stream carrying parameters or network inputs.
REQ-006 data_valid  input  1  data_in holds a byte this cycle.
REQ-007 load_params  input  1  single-cycle request to start a parameter load.
REQ-008 start  input  1  single-cycle request to load inputs and run an inference.
REQ-009 abort  input  1  synchronous abort to IDLE.
REQ-010 out_ready  input  1  consumer accepts the current result.
REQ-011 param_we  output  1  write strobe to the parameter register bank.
REQ-012 param_addr  output  5  parameter slot index 0..N_PARAM-1.
REQ-013 param_data  output  8  byte written to the parameter bank.
REQ-014 input_we  output  1  write strobe to the neuron-input registers.
REQ-015 input_idx  output  2  neuron input index 0..3.
REQ-016 input_data  output  8  byte written to the neuron-input registers.
REQ-017 compute_en  output  1  enables the perceptron datapath.
REQ-018 result_sel  output  2  neuron output selected for presentation.
REQ-019 out_valid  output  1  result_sel output is valid.
REQ-020 params_loaded  output  1  a complete parameter set is present.
REQ-021 busy  output  1  state is not IDLE.
REQ-022 done  output  1  one-cycle pulse at end of an inference.
REQ-023 err  output  1  one-cycle pulse when start is refused.

Function
REQ-024 States: IDLE, LOAD_PARAM, LOAD_INPUT, COMPUTE, OUTPUT; all outputs registered.
REQ-025 IDLE: load_params -> LOAD_PARAM, count cleared, params_loaded cleared; else start with params_loaded=1 -> LOAD_INPUT; start with params_loaded=0 -> stay IDLE, err pulses next cycle.
REQ-026 IDLE, load_params and start in the same cycle: load_params wins, start is dropped, no err.
REQ-027 LOAD_PARAM: each data_valid cycle -> next cycle param_we=1, param_addr=count, param_data=data_in; count increments; no write on cycles without data_valid.
REQ-028 LOAD_PARAM: byte with count=N_PARAM-1 accepted -> params_loaded=1 and IDLE next cycle; subsequent data_valid ignored.
REQ-029 LOAD_INPUT: same write timing on input_we/input_idx/input_data; after the 4th byte (idx 3) -> COMPUTE.
REQ-030 COMPUTE: compute_en=1 for exactly COMPUTE_CYCLES consecutive cycles, then OUTPUT with result_sel=0.
REQ-031 OUTPUT: out_valid=1; result_sel holds while out_ready=0; out_ready=1 -> result_sel increments next cycle.
REQ-032 OUTPUT: acceptance at result_sel=3 -> IDLE, out_valid=0, done=1 for one cycle.
REQ-033 data_valid outside LOAD_PARAM/LOAD_INPUT is ignored; load_params/start outside IDLE are ignored.
REQ-034 abort in any non-IDLE state -> IDLE next cycle, all strobes, compute_en, out_valid low; abort from LOAD_PARAM leaves params_loaded=0; otherwise params_loaded retained; done not asserted.
REQ-035 abort has priority over data_valid and out_ready in the same cycle; the byte is not written.
REQ-036 param_we and input_we never high in the same cycle; at most one write per cycle.

Reset
REQ-037 rst_n low -> immediately: state IDLE, counters 0, all outputs 0 (incl. params_loaded, param_addr, input_idx, result_sel); reset mid-operation discards all progress.

Verification
REQ-038 Reset, start with no load -> err=1 one cycle, busy stays 0, no write strobes.
REQ-039 load_params, 20 bytes 0x00..0x13 with gaps in data_valid -> 20 param_we pulses, addr 0..19, data == addr, params_loaded=1, IDLE.
REQ-040 After load, start, inputs 0xA1..0xA4 -> input_idx 0..3, compute_en high 2 cycles, out_valid with result_sel 0; out_ready held 1 -> sel 0,1,2,3, done pulse, IDLE.
REQ-041 OUTPUT with out_ready low 5 cycles at sel 2 -> sel stays 2, out_valid stays 1; then advances.
REQ-042 abort after 7 parameter bytes -> IDLE next cycle, params_loaded=0; start then -> err pulse.
REQ-043 rst_n low during COMPUTE -> compute_en=0 immediately, all outputs 0; load_params and start together in IDLE -> LOAD_PARAM, no err.

Source files
------------

// File: rtl/nn_load_sequencer.sv
// Control sequencer for a 4-neuron perceptron: streams parameters and inputs into
// register banks, times the compute window, then presents the four results in order.
module nn_load_sequencer #(
  parameter int N_PARAM        = 20,
  parameter int COMPUTE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       load_params,
  input  logic       start,
  input  logic       abort,
  input  logic       out_ready,
  output logic       param_we,
  output logic [4:0] param_addr,
  output logic [7:0] param_data,
  output logic       input_we,
  output logic [1:0] input_idx,
  output logic [7:0] input_data,
  output logic       compute_en,
  output logic [1:0] result_sel,
  output logic       out_valid,
  output logic       params_loaded,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, LOAD_PARAM, LOAD_INPUT, COMPUTE, OUTPUT} state_t;

  localparam logic [4:0] LAST_P = 5'(N_PARAM - 1);
  localparam logic [3:0] CC     = 4'(COMPUTE_CYCLES);

  state_t     state;
  logic [4:0] cnt;
  logic [3:0] ccnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ccnt          <= '0;
      param_we      <= 1'b0;
      param_addr    <= '0;
      param_data    <= '0;
      input_we      <= 1'b0;
      input_idx     <= '0;
      input_data    <= '0;
      compute_en    <= 1'b0;
      result_sel    <= '0;
      out_valid     <= 1'b0;
      params_loaded <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      param_we <= 1'b0;
      input_we <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      // abort beats any data or handshake in the same cycle
      if (abort && state != IDLE) begin
        state      <= IDLE;
        busy       <= 1'b0;
        compute_en <= 1'b0;
        out_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load_params) begin
              state         <= LOAD_PARAM;
              cnt           <= '0;
              params_loaded <= 1'b0;
              busy          <= 1'b1;
            end else if (start) begin
              if (params_loaded) begin
                state <= LOAD_INPUT;
                cnt   <= '0;
                busy  <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          LOAD_PARAM: begin
            if (data_valid) begin
              param_we   <= 1'b1;
              param_addr <= cnt;
              param_data <= data_in;
              cnt        <= cnt + 5'd1;
              if (cnt == LAST_P) begin
                params_loaded <= 1'b1;
                state         <= IDLE;
                busy          <= 1'b0;
              end
            end
          end
          LOAD_INPUT: begin
            if (data_valid) begin
              input_we   <= 1'b1;
              input_idx  <= cnt[1:0];
              input_data <= data_in;
              cnt        <= cnt + 5'd1;
              if (cnt[1:0] == 2'd3) begin
                state      <= COMPUTE;
                compute_en <= 1'b1;
                ccnt       <= 4'd1;
              end
            end
          end
          COMPUTE: begin
            // ccnt counts cycles compute_en has already been high
            if (ccnt == CC) begin
              compute_en <= 1'b0;
              state      <= OUTPUT;
              out_valid  <= 1'b1;
              result_sel <= '0;
            end else begin
              ccnt <= ccnt + 4'd1;
            end
          end
          OUTPUT: begin
            if (out_ready) begin
              if (result_sel == 2'd3) begin
                out_valid  <= 1'b0;
                done       <= 1'b1;
                result_sel <= '0;
                state      <= IDLE;
                busy       <= 1'b0;
              end else begin
                result_sel <= result_sel + 2'd1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_load_sequencer.sv
// Bench for nn_load_sequencer: a vector table for IDLE/abort corners, directed sessions,
// and random load/infer sessions checked against a transaction-level expectation.
module tb_nn_load_sequencer;
  localparam int N_PARAM = 20;
  localparam int CCYC    = 2;

  logic       clk, rst_n;
  logic [7:0] data_in;
  logic       data_valid, load_params, start, abort, out_ready;
  logic       param_we, input_we, compute_en, out_valid, params_loaded, busy, done, err;
  logic [4:0] param_addr;
  logic [7:0] param_data, input_data;
  logic [1:0] input_idx, result_sel;

  nn_load_sequencer #(.N_PARAM(N_PARAM), .COMPUTE_CYCLES(CCYC)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .load_params(load_params), .start(start), .abort(abort), .out_ready(out_ready),
    .param_we(param_we), .param_addr(param_addr), .param_data(param_data),
    .input_we(input_we), .input_idx(input_idx), .input_data(input_data),
    .compute_en(compute_en), .result_sel(result_sel), .out_valid(out_valid),
    .params_loaded(params_loaded), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit pl_model = 1'b0;

  // observed transactions, never cleared; sessions compare against a base snapshot
  logic [12:0] pw_q[$];
  logic [9:0]  iw_q[$];
  logic [1:0]  acc_q[$];
  int ce_cyc = 0, ce_rise = 0, done_cyc = 0, dual_we = 0;
  logic ce_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (param_we) pw_q.push_back({param_addr, param_data});
      if (input_we) iw_q.push_back({input_idx, input_data});
      if (param_we && input_we) dual_we++;
      if (compute_en) begin
        ce_cyc++;
        if (!ce_prev) ce_rise++;
      end
      if (out_valid && out_ready && !abort) acc_q.push_back(result_sel);
      if (done) done_cyc++;
    end
    ce_prev = compute_en;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    data_valid = 0; load_params = 0; start = 0; abort = 0; out_ready = 0; data_in = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {param_we, param_addr, param_data, input_we, input_idx, input_data, compute_en,
             result_sel, out_valid, params_loaded, busy, done, err}, 64'd0);
  endtask

  task automatic do_load(input int abort_at, input int gap_pct, input bit directed);
    int base, sent, cyc;
    logic [7:0] b;
    logic [12:0] exp_q[$];
    bit aborted;
    base = pw_q.size(); sent = 0; aborted = 0;
    load_params = 1; step; load_params = 0;
    chk("load_enter_busy", busy, 1);
    chk("load_enter_pl", params_loaded, 0);
    for (cyc = 0; cyc < 2000 && sent < N_PARAM; cyc++) begin
      if (abort_at >= 0 && sent == abort_at) begin
        abort = 1; data_valid = 1; data_in = 8'hEE;
        step; idle_inputs(); aborted = 1;
        chk("abort_busy", busy, 0);
        chk("abort_pl", params_loaded, 0);
        chk("abort_pwe", param_we, 0);
        break;
      end
      data_valid  = ($urandom_range(0, 99) >= gap_pct);
      b           = directed ? 8'(sent) : 8'($urandom);
      data_in     = b;
      start       = ($urandom_range(0, 7) == 0);
      load_params = ($urandom_range(0, 7) == 0);
      if (data_valid) begin
        exp_q.push_back({5'(sent), b});
        sent++;
      end
      step;
    end
    idle_inputs();
    if (!aborted && sent < N_PARAM) begin
      failures++;
      $display("FAIL load_timeout: got %0d bytes expected %0d", sent, N_PARAM);
    end
    step;
    pl_model = !aborted;
    chk("load_end_busy", busy, 0);
    chk("load_end_pl", params_loaded, pl_model);
    chk("pw_count", pw_q.size() - base, exp_q.size());
    foreach (exp_q[i])
      if (base + i < pw_q.size()) chk($sformatf("pw_%0d", i), pw_q[base + i], exp_q[i]);
  endtask

  task automatic do_infer(input int ready_pct, input bit directed, input int abort_cyc, input bit stall2);
    int ib, ab, cb, rb, db, sent, stall, cyc;
    logic [7:0] b;
    logic [9:0] exp_q[$];
    bit aborted, finished, stalled;
    ib = iw_q.size(); ab = acc_q.size(); cb = ce_cyc; rb = ce_rise; db = done_cyc;
    sent = 0; stall = 0; aborted = 0; finished = 0;
    start = 1; step; start = 0;
    if (!pl_model) begin
      chk("refuse_err", err, 1);
      chk("refuse_busy", busy, 0);
      step;
      chk("refuse_err_clear", err, 0);
      chk("refuse_busy2", busy, 0);
      chk("refuse_no_write", iw_q.size() - ib, 0);
      return;
    end
    chk("infer_busy", busy, 1);
    chk("infer_no_err", err, 0);
    for (cyc = 0; cyc < 200 && sent < 4; cyc++) begin
      data_valid = ($urandom_range(0, 99) >= 30);
      b          = directed ? 8'hA1 + 8'(sent) : 8'($urandom);
      data_in    = b;
      if (data_valid) begin
        exp_q.push_back({2'(sent), b});
        sent++;
      end
      step;
    end
    idle_inputs();
    for (cyc = 0; cyc < 300; cyc++) begin
      if (cyc == abort_cyc) begin
        abort = 1; out_ready = 1'($urandom_range(0, 1)); data_valid = 1;
        step; idle_inputs(); aborted = 1;
        chk("iabort_busy", busy, 0);
        chk("iabort_ce", compute_en, 0);
        chk("iabort_ov", out_valid, 0);
        chk("iabort_pl", params_loaded, 1);
        break;
      end
      stalled = stall2 && out_valid && result_sel == 2'd2 && stall < 5;
      if (stalled) begin
        out_ready = 0; stall++;
      end else begin
        out_ready = ($urandom_range(0, 99) < ready_pct);
      end
      data_valid  = 1'($urandom_range(0, 1));
      data_in     = 8'($urandom);
      start       = ($urandom_range(0, 5) == 0);
      load_params = ($urandom_range(0, 5) == 0);
      step;
      if (stalled) begin
        chk("stall_sel", result_sel, 2);
        chk("stall_ov", out_valid, 1);
      end
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    idle_inputs();
    if (!aborted && !finished) begin
      failures++;
      $display("FAIL infer_timeout: busy %0d after 300 cycles expected 0", busy);
    end
    step;
    chk("iw_count", iw_q.size() - ib, exp_q.size());
    foreach (exp_q[i])
      if (ib + i < iw_q.size()) chk($sformatf("iw_%0d", i), iw_q[ib + i], exp_q[i]);
    if (aborted) begin
      chk("iabort_no_done", done_cyc - db, 0);
    end else begin
      chk("ce_cycles", ce_cyc - cb, CCYC);
      chk("ce_rises", ce_rise - rb, 1);
      chk("acc_count", acc_q.size() - ab, 4);
      for (int i = 0; i < 4; i++)
        if (ab + i < acc_q.size()) chk($sformatf("acc_sel_%0d", i), acc_q[ab + i], i);
      chk("done_once", done_cyc - db, 1);
      chk("end_ov", out_valid, 0);
      chk("end_busy", busy, 0);
      if (stall2) chk("stall_len", stall, 5);
    end
  endtask

  typedef struct {
    logic lp, st, ab, dv;
    logic [7:0] d;
    logic e_busy, e_err, e_pwe;
    logic [4:0] e_addr;
    logic e_pl;
  } vec_t;
  vec_t tv[9];

  initial begin
    idle_inputs();
    rst_n = 1; #2 rst_n = 0; #1;
    chk_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;

    // lp st ab dv data  busy err pwe addr pl
    tv[0] = '{0, 1, 0, 0, 8'h00, 0, 1, 0, 5'd0, 0};  // start without params
    tv[1] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 5'd0, 0};
    tv[2] = '{1, 1, 0, 0, 8'h00, 1, 0, 0, 5'd0, 0};  // load_params beats start
    tv[3] = '{0, 0, 0, 1, 8'h55, 1, 0, 1, 5'd0, 0};
    tv[4] = '{0, 0, 0, 0, 8'h00, 1, 0, 0, 5'd0, 0};
    tv[5] = '{0, 0, 0, 1, 8'h66, 1, 0, 1, 5'd1, 0};
    tv[6] = '{0, 0, 1, 1, 8'h77, 0, 0, 0, 5'd0, 0};  // abort drops the byte
    tv[7] = '{0, 1, 0, 0, 8'h00, 0, 1, 0, 5'd0, 0};
    tv[8] = '{0, 0, 0, 1, 8'h88, 0, 0, 0, 5'd0, 0};  // data in IDLE ignored
    for (int i = 0; i < 9; i++) begin
      load_params = tv[i].lp; start = tv[i].st; abort = tv[i].ab;
      data_valid = tv[i].dv; data_in = tv[i].d;
      step;
      chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("tv%0d_err", i), err, tv[i].e_err);
      chk($sformatf("tv%0d_pwe", i), param_we, tv[i].e_pwe);
      chk($sformatf("tv%0d_pl", i), params_loaded, tv[i].e_pl);
      if (tv[i].e_pwe) begin
        chk($sformatf("tv%0d_addr", i), param_addr, tv[i].e_addr);
        chk($sformatf("tv%0d_data", i), param_data, tv[i].d);
      end
    end
    idle_inputs();
    step;

    do_load(-1, 40, 1);
    do_infer(100, 1, -1, 0);
    do_infer(100, 0, -1, 1);
    do_load(7, 20, 0);
    do_infer(100, 0, -1, 0);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) do_load($urandom_range(0, N_PARAM - 1), $urandom_range(0, 60), 0);
      else do_load(-1, $urandom_range(0, 60), 0);
      do_infer($urandom_range(30, 100), 0, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : -1, 0);
    end

    // reset while computing
    do_load(-1, 0, 0);
    start = 1; step; start = 0;
    data_valid = 1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'(i); step;
    end
    idle_inputs();
    chk("pre_reset_ce", compute_en, 1);
    #2 rst_n = 0; #1;
    chk_all_zero("reset_in_compute");
    @(negedge clk) rst_n = 1;
    pl_model = 0;
    step;
    chk_all_zero("after_reset_idle");
    do_infer(100, 0, -1, 0);

    chk("no_dual_write", dual_we, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running expected finish");
    $fatal(1);
  end
endmodule
